id_stage_pipe: RTL and testbench

//  Registered, parametrised RV32I/RV64I decode stage between fetch and execute. Decodes one instruction per

---
 rtl/rv_isa_pkg.sv | 35 +++
 rtl/rv_decode_comb.sv | 99 +++++++++
 rtl/id_stage_pipe.sv | 149 ++++++++++++++
 tb/tb_id_stage_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// rtl/rv_isa_pkg.sv - RV32I/RV64I opcode, write-back and decode-control definitions
package rv_isa_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_JALR = 2'd2,
    WB_JAL  = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic    op1_src;
    logic    op2_src;
    logic    mem_re;
    logic    mem_we;
    wb_src_e wb_src;
    logic    reg_we;
    logic    use_rs1;
    logic    use_rs2;
    logic    illegal;
  } dec_ctrl_t;

endpackage

// File: rtl/rv_decode_comb.sv
// rtl/rv_decode_comb.sv - combinational instruction decoder (fields, immediate, control)
module rv_decode_comb
  import rv_isa_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic [31:0]     instr_i,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [XLEN-1:0] imm_o,
  output dec_ctrl_t       ctrl_o
);

  logic [6:0]  opcode;
  logic [31:0] imm32;
  logic        writes_rd;

  assign opcode   = instr_i[6:0];
  assign rd_o     = instr_i[11:7];
  assign rs2_o    = instr_i[24:20];
  assign funct3_o = instr_i[14:12];
  assign imm_o    = XLEN'($signed(imm32));

  always_comb begin
    ctrl_o         = '0;
    ctrl_o.op2_src = 1'b1;
    ctrl_o.wb_src  = WB_ALU;
    imm32          = '0;
    writes_rd      = 1'b0;
    funct7_o       = '0;
    rs1_o          = instr_i[19:15];
    case (opcode)
      OP: begin
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        ctrl_o.op2_src = 1'b0;
        funct7_o       = instr_i[31:25];
        writes_rd      = 1'b1;
        ctrl_o.illegal = (ENABLE_M == 0) && (instr_i[31:25] == FUNCT7_MULDIV);
      end
      OP_IMM: begin
        ctrl_o.use_rs1 = 1'b1;
        imm32          = {{20{instr_i[31]}}, instr_i[31:20]};
        writes_rd      = 1'b1;
      end
      LOAD: begin
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.mem_re  = 1'b1;
        ctrl_o.wb_src  = WB_MEM;
        imm32          = {{20{instr_i[31]}}, instr_i[31:20]};
        writes_rd      = 1'b1;
      end
      STORE: begin
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        ctrl_o.mem_we  = 1'b1;
        imm32          = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      BRANCH: begin
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.use_rs2 = 1'b1;
        ctrl_o.op1_src = 1'b1;
        imm32          = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                          instr_i[30:25], instr_i[11:8], 1'b0};
      end
      JAL: begin
        ctrl_o.op1_src = 1'b1;
        ctrl_o.wb_src  = WB_JAL;
        imm32          = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                          instr_i[20], instr_i[30:21], 1'b0};
        writes_rd      = 1'b1;
      end
      JALR: begin
        ctrl_o.use_rs1 = 1'b1;
        ctrl_o.wb_src  = WB_JALR;
        imm32          = {{20{instr_i[31]}}, instr_i[31:20]};
        writes_rd      = 1'b1;
      end
      LUI: begin
        // lui adds to x0 so the ALU path can stay op1 + imm
        rs1_o     = 5'd0;
        imm32     = {instr_i[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      AUIPC: begin
        ctrl_o.op1_src = 1'b1;
        imm32          = {instr_i[31:12], 12'b0};
        writes_rd      = 1'b1;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
    ctrl_o.reg_we = writes_rd && (rd_o != 5'd0) && !ctrl_o.illegal;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - decode stage with ID/EX register, load-use interlock and stall counter
module id_stage_pipe
  import rv_isa_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ENABLE_M     = 1,
  parameter int HAZARD_CHECK = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_op1_src,
  output logic             out_op2_src,
  output logic             out_mem_re,
  output logic             out_mem_we,
  output logic [1:0]       out_wb_src,
  output logic             out_reg_we,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            op1_src;
    logic            op2_src;
    logic            mem_re;
    logic            mem_we;
    logic [1:0]      wb_src;
    logic            reg_we;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            illegal;
  } idex_t;

  logic [4:0]      d_rs1, d_rs2, d_rd;
  logic [2:0]      d_funct3;
  logic [6:0]      d_funct7;
  logic [XLEN-1:0] d_imm;
  dec_ctrl_t       d_ctrl;

  idex_t           idex_q, idex_d;
  logic            valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            hazard, accept;

  rv_decode_comb #(.XLEN(XLEN), .ENABLE_M(ENABLE_M)) u_decode (
    .instr_i  (in_instr),
    .rs1_o    (d_rs1),
    .rs2_o    (d_rs2),
    .rd_o     (d_rd),
    .funct3_o (d_funct3),
    .funct7_o (d_funct7),
    .imm_o    (d_imm),
    .ctrl_o   (d_ctrl)
  );

  // The load in ID/EX has no data until after memory, so a dependent consumer must wait one slot.
  assign hazard = (HAZARD_CHECK != 0) && valid_q && idex_q.mem_re && (idex_q.rd != 5'd0) &&
                  ((d_ctrl.use_rs1 && (d_rs1 == idex_q.rd)) ||
                   (d_ctrl.use_rs2 && (d_rs2 == idex_q.rd)));
  assign in_ready = rst_n && !flush && !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    idex_d  = idex_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (hazard) begin
      if (out_ready) begin
        valid_d = 1'b0;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (accept) begin
      valid_d        = 1'b1;
      idex_d.pc      = in_pc;
      idex_d.rs1     = d_rs1;
      idex_d.rs2     = d_rs2;
      idex_d.rd      = d_rd;
      idex_d.imm     = d_imm;
      idex_d.op1_src = d_ctrl.op1_src;
      idex_d.op2_src = d_ctrl.op2_src;
      idex_d.mem_re  = d_ctrl.mem_re;
      idex_d.mem_we  = d_ctrl.mem_we;
      idex_d.wb_src  = d_ctrl.wb_src;
      idex_d.reg_we  = d_ctrl.reg_we;
      idex_d.funct3  = d_funct3;
      idex_d.funct7  = d_funct7;
      idex_d.illegal = d_ctrl.illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
    // Side-effecting strobes must never be seen high on an empty slot.
    if (!valid_d) begin
      idex_d.mem_re = 1'b0;
      idex_d.mem_we = 1'b0;
      idex_d.reg_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idex_q  <= idex_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = idex_q.pc;
  assign out_rs1     = idex_q.rs1;
  assign out_rs2     = idex_q.rs2;
  assign out_rd      = idex_q.rd;
  assign out_imm     = idex_q.imm;
  assign out_op1_src = idex_q.op1_src;
  assign out_op2_src = idex_q.op2_src;
  assign out_mem_re  = idex_q.mem_re;
  assign out_mem_we  = idex_q.mem_we;
  assign out_wb_src  = idex_q.wb_src;
  assign out_reg_we  = idex_q.reg_we;
  assign out_funct3  = idex_q.funct3;
  assign out_funct7  = idex_q.funct7;
  assign out_illegal = idex_q.illegal;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - scoreboard bench for id_stage_pipe (RV32 with M, RV64 without M)
module tb_id_stage_pipe;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        op1;
    logic        op2;
    logic        re;
    logic        we;
    logic [1:0]  wb;
    logic        rwe;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] in_instr;
  logic [63:0] pc_ctr;
  logic [31:0] in_pc32;
  logic [63:0] in_pc64;
  bit          rand_rdy = 0;

  logic        a_ready, a_valid, a_op1, a_op2, a_re, a_we, a_rwe, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [1:0]  a_wb;
  logic [2:0]  a_f3;
  logic [6:0]  a_f7;
  logic [15:0] a_stall;

  logic        b_ready, b_valid, b_op1, b_op2, b_re, b_we, b_rwe, b_ill;
  logic [63:0] b_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [1:0]  b_wb;
  logic [2:0]  b_f3;
  logic [6:0]  b_f7;
  logic [15:0] b_stall;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   w;
  int   exp_stall;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  logic [63:0] beq_pc;
  logic [31:0] tbl [10] = '{32'h00532623, 32'hABCDE537, 32'h80000197, 32'hFF8280E7,
                            32'hFFF10113, 32'h40628233, 32'h0044A483, 32'h00948533,
                            32'h0000007F, 32'h00208463};

  assign in_pc32 = pc_ctr[31:0];
  assign in_pc64 = pc_ctr;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .ENABLE_M(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ready), .in_instr(in_instr),
    .in_pc(in_pc32), .flush(flush), .out_valid(a_valid), .out_ready(out_ready), .out_pc(a_pc),
    .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm), .out_op1_src(a_op1),
    .out_op2_src(a_op2), .out_mem_re(a_re), .out_mem_we(a_we), .out_wb_src(a_wb),
    .out_reg_we(a_rwe), .out_funct3(a_f3), .out_funct7(a_f7), .out_illegal(a_ill),
    .stall_cnt(a_stall)
  );

  id_stage_pipe #(.XLEN(64), .ENABLE_M(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ready), .in_instr(in_instr),
    .in_pc(in_pc64), .flush(flush), .out_valid(b_valid), .out_ready(out_ready), .out_pc(b_pc),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm), .out_op1_src(b_op1),
    .out_op2_src(b_op2), .out_mem_re(b_re), .out_mem_we(b_we), .out_wb_src(b_wb),
    .out_reg_we(b_rwe), .out_funct3(b_f3), .out_funct7(b_f7), .out_illegal(b_ill),
    .stall_cnt(b_stall)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc, input bit en_m);
    exp_t        e;
    logic [31:0] imm;
    bit          wr;
    e     = '0;
    imm   = '0;
    wr    = 0;
    e.pc  = pc;
    e.rd  = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.f3  = ins[14:12];
    e.op2 = 1'b1;
    case (ins[6:0])
      7'h33: begin e.op2 = 1'b0; e.f7 = ins[31:25]; wr = 1;
                   e.ill = !en_m && (ins[31:25] == 7'h01); end
      7'h13: begin imm = {{20{ins[31]}}, ins[31:20]}; wr = 1; end
      7'h03: begin imm = {{20{ins[31]}}, ins[31:20]}; e.re = 1'b1; e.wb = 2'd1; wr = 1; end
      7'h23: begin imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; e.we = 1'b1; end
      7'h63: begin imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; e.op1 = 1'b1; end
      7'h6F: begin imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
                   e.op1 = 1'b1; e.wb = 2'd3; wr = 1; end
      7'h67: begin imm = {{20{ins[31]}}, ins[31:20]}; e.wb = 2'd2; wr = 1; end
      7'h37: begin imm = {ins[31:12], 12'h000}; e.rs1 = 5'd0; wr = 1; end
      7'h17: begin imm = {ins[31:12], 12'h000}; e.op1 = 1'b1; wr = 1; end
      default: e.ill = 1'b1;
    endcase
    e.rwe = wr && (ins[11:7] != 5'd0) && !e.ill;
    e.imm = {{32{imm[31]}}, imm};
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_valid && (flush || out_ready)) begin
        if (q_a.size() == 0) check("sb_a_underflow", 64'(1), 64'(0));
        else begin
          e_a = q_a.pop_front();
          if (!flush) begin
            check("a_pc", 64'(a_pc), 64'(e_a.pc[31:0]));
            check("a_imm", 64'(a_imm), 64'(e_a.imm[31:0]));
            check("a_ctrl", 64'({a_op1, a_op2, a_re, a_we, a_wb, a_rwe, a_ill}),
                  64'({e_a.op1, e_a.op2, e_a.re, e_a.we, e_a.wb, e_a.rwe, e_a.ill}));
            check("a_fields", 64'({a_rs1, a_rs2, a_rd, a_f3, a_f7}),
                  64'({e_a.rs1, e_a.rs2, e_a.rd, e_a.f3, e_a.f7}));
          end
        end
      end
      if (in_valid && a_ready) q_a.push_back(model(in_instr, {32'h0, in_pc32}, 1'b1));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_valid && (flush || out_ready)) begin
        if (q_b.size() == 0) check("sb_b_underflow", 64'(1), 64'(0));
        else begin
          e_b = q_b.pop_front();
          if (!flush) begin
            check("b_pc", b_pc, e_b.pc);
            check("b_imm", b_imm, e_b.imm);
            check("b_ctrl", 64'({b_op1, b_op2, b_re, b_we, b_wb, b_rwe, b_ill}),
                  64'({e_b.op1, e_b.op2, e_b.re, e_b.we, e_b.wb, e_b.rwe, e_b.ill}));
            check("b_fields", 64'({b_rs1, b_rs2, b_rd, b_f3, b_f7}),
                  64'({e_b.rs1, e_b.rs2, e_b.rd, e_b.f3, e_b.f7}));
          end
        end
      end
      if (in_valid && b_ready) q_b.push_back(model(in_instr, in_pc64, 1'b0));
    end
  end

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, output int waited);
    bit acc;
    acc      = 0;
    waited   = 0;
    in_valid = 1'b1;
    in_instr = ins;
    while (!acc) begin
      @(negedge clk);
      acc = a_ready;
      check("ready_match", 64'(b_ready), 64'(a_ready));
      settle();
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      if (!acc) begin
        waited++;
        if (waited > 50) begin
          check("issue_timeout", 64'(0), 64'(1));
          acc = 1;
        end
      end
    end
    in_valid = 1'b0;
    in_instr = NOP;
    pc_ctr   = pc_ctr + 64'd4;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (3) settle();
  endtask

  task automatic hold_issue(input logic [31:0] ins);
    int wt;
    drain();
    out_ready = 1'b0;
    issue(ins, wt);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_instr  = NOP;
    flush     = 1'b0;
    out_ready = 1'b0;
    pc_ctr    = 64'h0000_0001_8000_0000;
    exp_stall = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(a_valid), 64'(0));
    check("rst_in_ready", 64'(a_ready), 64'(0));
    check("rst_stall", 64'(a_stall), 64'(0));
    check("rst_we", 64'({a_rwe, a_re, a_we}), 64'(0));
    check("rst_pc_imm", 64'({a_pc, a_imm}), 64'(0));
    check("rst_b", 64'({b_valid, b_ready, b_stall}), 64'(0));
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'({a_ready, b_ready}), 64'(2'b11));
    settle();

    out_ready = 1'b1;
    issue(32'h00700293, w);
    check("addi_wait", 64'(w), 64'(0));
    @(negedge clk);
    check("addi_valid", 64'(a_valid), 64'(1));
    check("addi_rd", 64'(a_rd), 64'(5));
    check("addi_imm", 64'(a_imm), 64'(7));
    check("addi_we_op2", 64'({a_rwe, a_op2}), 64'(2'b11));
    settle();

    issue(32'h0000A303, w);
    issue(32'h002303B3, w);
    exp_stall = exp_stall + 1;
    check("loaduse_bubble", 64'(w), 64'(1));
    @(negedge clk);
    check("loaduse_stall", 64'(a_stall), 64'(exp_stall));
    check("loaduse_stall_b", 64'(b_stall), 64'(exp_stall));
    settle();

    issue(32'h0000A003, w);
    issue(32'h002003B3, w);
    check("x0_nobubble", 64'(w), 64'(0));
    @(negedge clk);
    check("x0_stall", 64'(a_stall), 64'(exp_stall));
    settle();

    drain();
    out_ready = 1'b0;
    beq_pc    = pc_ctr;
    issue(32'h00208463, w);
    in_valid = 1'b1;
    in_instr = 32'h00700293;
    repeat (3) begin
      @(negedge clk);
      check("hold_in_ready", 64'(a_ready), 64'(0));
      check("hold_valid", 64'(a_valid), 64'(1));
      check("hold_imm", 64'(a_imm), 64'(8));
      check("hold_pc", 64'(a_pc), 64'(beq_pc[31:0]));
    end
    settle();
    out_ready = 1'b1;
    issue(32'h00700293, w);
    check("hold_release", 64'(w), 64'(0));

    drain();
    out_ready = 1'b0;
    issue(32'h0000A303, w);
    in_valid = 1'b1;
    in_instr = 32'h002303B3;
    flush    = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(a_ready), 64'(0));
    settle();
    flush    = 1'b0;
    in_valid = 1'b0;
    in_instr = NOP;
    @(negedge clk);
    check("flush_valid", 64'({a_valid, b_valid}), 64'(0));
    check("flush_stall", 64'(a_stall), 64'(exp_stall));
    settle();

    hold_issue(32'hFFDFF0EF);
    check("jal_imm32", 64'(a_imm), 64'(32'hFFFF_FFFC));
    check("jal_imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    settle();
    hold_issue(32'h023100B3);
    check("mul_ill", 64'({a_ill, b_ill}), 64'(2'b01));
    check("mul_we", 64'({a_rwe, b_rwe}), 64'(2'b10));
    settle();
    hold_issue(32'hFFFFFFFF);
    check("opc7f_ill", 64'({a_ill, b_ill}), 64'(2'b11));
    check("opc7f_strobes", 64'({a_rwe, a_re, a_we, b_rwe}), 64'(0));
    settle();

    drain();
    rand_rdy = 1;
    for (int i = 0; i < 16; i++) begin
      issue((i < 10) ? tbl[i] : 32'($urandom()), w);
    end
    rand_rdy = 0;
    drain();
    check("sb_a_empty", 64'(q_a.size()), 64'(0));
    check("sb_b_empty", 64'(q_b.size()), 64'(0));

    out_ready = 1'b0;
    issue(32'h00700293, w);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'({a_valid, b_valid}), 64'(0));
    check("async_rst_stall", 64'({a_stall, b_stall}), 64'(0));
    q_a.delete();
    q_b.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
